adder_response_checker: RTL and testbench

- Sequential response analyser at the output side of the Lab2 adder datapath.
- Consumes each applied vector (a, b, cin) together with the adder's response (sum, cout) and compares it against a golden a+b+cin.
- Counts vectors and mismatches, captures the first failing vector, and compacts responses into a MISR signature.
- Lets a stimulus sweep be graded in hardware instead of by waveform inspection.

---
 rtl/lab2_pkg.sv | 14 +
 rtl/misr_reg.sv | 37 +++
 rtl/adder_response_checker.sv | 152 +++++++++++++++
 tb/tb_adder_response_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab2_pkg.sv
// Shared definitions for the Lab2 adder response checker: state encoding and
// default datapath width / MISR polynomial.
package lab2_pkg;

  localparam int         DEF_WIDTH = 8;
  localparam logic [8:0] DEF_POLY  = 9'h11D;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/misr_reg.sv
// Multiple-input signature register: shifts left, folds the top bit back
// through POLY, and XORs in one response word per enabled cycle.
module misr_reg #(
  parameter int           W    = 9,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/adder_response_checker.sv
// Grades adder responses against a golden a+b+cin: counts vectors and
// mismatches, latches the first failure and compacts responses into a MISR.
module adder_response_checker
  import lab2_pkg::*;
#(
  parameter int             WIDTH = DEF_WIDTH,
  parameter logic [WIDTH:0] POLY  = (WIDTH+1)'(DEF_POLY),
  parameter int             ERR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic                 vec_last,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 cin,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic                 fail_valid,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_cin,
  output logic [WIDTH:0]       fail_got,
  output logic [WIDTH:0]       signature
);

  localparam int VC_W = 2*WIDTH+2;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [VC_W-1:0]    vec_count_q, vec_count_d;
  logic               fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0]   fail_a_q, fail_a_d;
  logic [WIDTH-1:0]   fail_b_q, fail_b_d;
  logic               fail_cin_q, fail_cin_d;
  logic [WIDTH:0]     fail_got_q, fail_got_d;

  logic               start_run;
  logic               accept;
  logic               mismatch;
  logic [WIDTH:0]     exp_resp;
  logic [WIDTH:0]     got_resp;

  // start is only honoured outside RUN; a vector in that same cycle is dropped.
  assign start_run = start && (state_q != ST_RUN);
  assign accept    = vec_valid && (state_q == ST_RUN);
  assign exp_resp  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign got_resp  = {cout, sum};
  assign mismatch  = accept && (got_resp != exp_resp);

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_count_d  = err_count_q;
    vec_count_d  = vec_count_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    fail_cin_d   = fail_cin_q;
    fail_got_d   = fail_got_q;
    if (start_run) begin
      state_d      = ST_RUN;
      busy_d       = 1'b1;
      done_d       = 1'b0;
      err_count_d  = '0;
      vec_count_d  = '0;
      fail_valid_d = 1'b0;
      fail_a_d     = '0;
      fail_b_d     = '0;
      fail_cin_d   = 1'b0;
      fail_got_d   = '0;
    end else if (accept) begin
      vec_count_d = vec_count_q + 1'b1;
      if (mismatch) begin
        if (err_count_q != '1) begin
          err_count_d = err_count_q + 1'b1;
        end
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          fail_a_d     = a;
          fail_b_d     = b;
          fail_cin_d   = cin;
          fail_got_d   = got_resp;
        end
      end
      if (vec_last) begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
      vec_count_q  <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_cin_q   <= 1'b0;
      fail_got_q   <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      vec_count_q  <= vec_count_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      fail_cin_q   <= fail_cin_d;
      fail_got_q   <= fail_got_d;
    end
  end

  misr_reg #(
    .W    (WIDTH+1),
    .POLY (POLY)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start_run),
    .en    (accept),
    .data  (got_resp),
    .sig   (signature)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_count_q == '0);
  assign err_count  = err_count_q;
  assign vec_count  = vec_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_cin   = fail_cin_q;
  assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_adder_response_checker.sv
// Bench for adder_response_checker: driver pushes the expected per-cycle result
// snapshot from a reference model, a negedge monitor pops and compares.
module tb_adder_response_checker;

  localparam int SNAP_W = 65;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic       vec_last = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] sum = '0;
  logic       cout = 1'b0;
  logic       busy, done, pass, fail_valid, fail_cin;
  logic [7:0] err_count, fail_a, fail_b;
  logic [17:0] vec_count;
  logic [8:0] fail_got, signature;

  adder_response_checker #(
    .WIDTH (8),
    .POLY  (9'h11D),
    .ERR_W (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .vec_valid  (vec_valid),
    .vec_last   (vec_last),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .sum        (sum),
    .cout       (cout),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .vec_count  (vec_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b),
    .fail_cin   (fail_cin),
    .fail_got   (fail_got),
    .signature  (signature)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [SNAP_W-1:0] exp_q[$];

  // Reference model: 0=idle 1=run 2=done.
  int m_mode, m_ec, m_vc, m_fv, m_fa, m_fb, m_fcin, m_fgot, m_sig;

  task automatic model_reset();
    m_mode = 0; m_ec = 0; m_vc = 0; m_fv = 0;
    m_fa = 0; m_fb = 0; m_fcin = 0; m_fgot = 0; m_sig = 0;
  endtask

  task automatic model_step();
    int exp_r, got_r;
    if (m_mode != 1 && start) begin
      m_mode = 1; m_ec = 0; m_vc = 0; m_fv = 0;
      m_fa = 0; m_fb = 0; m_fcin = 0; m_fgot = 0; m_sig = 0;
    end else if (m_mode == 1 && vec_valid) begin
      exp_r = int'(a) + int'(b) + int'(cin);
      got_r = int'(cout) * 256 + int'(sum);
      m_vc = (m_vc + 1) % 262144;
      if (got_r != exp_r) begin
        if (m_ec < 255) m_ec = m_ec + 1;
        if (m_fv == 0) begin
          m_fv = 1; m_fa = a; m_fb = b; m_fcin = cin; m_fgot = got_r;
        end
      end
      m_sig = (((m_sig * 2) % 512) ^ ((m_sig >= 256) ? 'h11D : 0) ^ got_r) % 512;
      if (vec_last) m_mode = 2;
    end
  endtask

  function automatic logic [SNAP_W-1:0] model_snap();
    logic [SNAP_W-1:0] s;
    s = {(m_mode == 1), (m_mode == 2), (m_mode == 2 && m_ec == 0), 8'(m_ec), 18'(m_vc),
         1'(m_fv), 8'(m_fa), 8'(m_fb), 1'(m_fcin), 9'(m_fgot), 9'(m_sig)};
    return s;
  endfunction

  function automatic logic [SNAP_W-1:0] dut_snap();
    logic [SNAP_W-1:0] s;
    s = {busy, done, pass, err_count, vec_count, fail_valid, fail_a, fail_b,
         fail_cin, fail_got, signature};
    return s;
  endfunction

  task automatic check(input string name, input logic [SNAP_W-1:0] got, input logic [SNAP_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: results of each driven cycle are visible by the following negedge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("snapshot", dut_snap(), exp_q.pop_front());
    end
  end

  // Driver: called at posedge+1, applies one cycle of inputs.
  task automatic drive(input logic st, input logic vv, input logic vl,
                       input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input logic [8:0] resp);
    start = st; vec_valid = vv; vec_last = vl;
    a = ia; b = ib; cin = ic; sum = resp[7:0]; cout = resp[8];
    @(posedge clk);
    model_step();
    exp_q.push_back(model_snap());
    #1;
    start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
  endtask

  task automatic drive_ok(input logic vl, input logic [7:0] ia, input logic [7:0] ib, input logic ic);
    drive(1'b0, 1'b1, vl, ia, ib, ic, 9'({1'b0, ia} + {1'b0, ib} + {8'd0, ic}));
  endtask

  // fault: 0 none, 1 sum bit0 flipped at a=0F/b=01/cin=0, 2 cout stuck at 0
  task automatic sweep(input int a_hi, input int fault);
    logic [8:0] resp;
    logic       lst;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    for (int ia = 0; ia <= a_hi; ia++) begin
      for (int ib = 0; ib < 256; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          resp = 9'(ia + ib + ic);
          if (fault == 1 && ia == 15 && ib == 1 && ic == 0) resp = resp ^ 9'h001;
          if (fault == 2) resp[8] = 1'b0;
          lst = (ia == a_hi && ib == 255 && ic == 1);
          drive(1'b0, 1'b1, lst, 8'(ia), 8'(ib), 1'(ic), resp);
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] rr;
    model_reset();
    #2;
    check("reset_state", dut_snap(), '0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle: vectors ignored, nothing changes.
    drive_ok(1'b1, 8'h12, 8'h34, 1'b0);
    drive_ok(1'b0, 8'hFF, 8'hFF, 1'b1);

    // Correct partial sweep, a = 0..15.
    sweep(15, 0);
    settle();
    check("sweep_ok_done_pass", {done, pass, err_count, fail_valid}, {1'b1, 1'b1, 8'h00, 1'b0});
    check("sweep_ok_count", 65'(vec_count), 65'(18'd8192));

    // Single injected sum-bit fault.
    sweep(16, 1);
    settle();
    check("inj_err_count", {pass, err_count}, {1'b0, 8'd1});
    check("inj_fail_vec", {fail_valid, fail_a, fail_b, fail_cin, fail_got},
          {1'b1, 8'h0F, 8'h01, 1'b0, 9'h011});
    check("inj_count", 65'(vec_count), 65'(18'd8704));

    // cout stuck at 0: 256 carry vectors in a=0..15, counter saturates.
    sweep(15, 2);
    settle();
    check("carry_err_sat", {pass, err_count}, {1'b0, 8'hFF});
    check("carry_fail_vec", {fail_valid, fail_a, fail_b, fail_cin, fail_got},
          {1'b1, 8'h00, 8'hFF, 1'b1, 9'h000});

    // MISR: responses 0x001, 0x002, 0x100 from a cleared signature.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    drive_ok(1'b0, 8'h01, 8'h00, 1'b0);
    drive_ok(1'b0, 8'h01, 8'h01, 1'b0);
    drive_ok(1'b1, 8'hFF, 8'h01, 1'b0);
    settle();
    check("misr_sig", 65'(signature), 65'(9'h100));
    check("misr_pass", {done, pass, vec_count}, {1'b1, 1'b1, 18'd3});

    // Control corners.
    drive(1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 9'h002);   // in DONE: ignored
    drive(1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 9'h003);   // start+vec: cleared, not counted
    settle();
    check("restart_clears", {busy, done, err_count, vec_count, fail_valid, signature},
          {1'b1, 1'b0, 8'h00, 18'd0, 1'b0, 9'h000});
    drive(1'b0, 1'b1, 1'b0, 8'h05, 8'h06, 1'b0, 9'h00B);
    drive(1'b1, 1'b1, 1'b0, 8'h07, 8'h08, 1'b1, 9'h010);   // start in RUN ignored
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 9'h000);   // last without valid
    settle();
    check("run_corners", {busy, vec_count, err_count}, {1'b1, 18'd2, 8'd0});
    drive_ok(1'b1, 8'h80, 8'h80, 1'b0);

    // Randomized traffic with occasional faults, gaps, starts and lasts.
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rr = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      if ($urandom_range(0, 9) == 0) rr = rr ^ 9'($urandom_range(1, 511));
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 29) == 0), ra, rb, rc, rr);
    end

    // Reset mid-run after 100 vectors.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    for (int i = 0; i < 100; i++) begin
      drive_ok(1'b0, 8'(i), 8'(3 * i), 1'b0);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", dut_snap(), '0);
    #1;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
    drive_ok(1'b1, 8'hA5, 8'h5A, 1'b1);
    settle();
    check("after_reset_run", {done, pass, vec_count}, {1'b1, 1'b1, 18'd1});

    repeat (3) @(negedge clk);
    #1;
    check("queue_drained", 65'(exp_q.size()), 65'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
